huffman_bit_aligner: RTL
========================

// Module: huffman_bit_aligner
// PURPOSE
// - Upstream feeder for the Huffman decoder. Packs a byte stream into a bit buffer and presents the next WIN_W bits MSB-first as a sliding window.
// - Each cycle the decoder reports how many bits it used (consume + consumeLen); the aligner discards exactly that many bits.
// - Handles start-up fill, back-pressure to the byte source and end-of-stream drain with zero padding.
// PARAMETERS
// - IN_W   8   input byte width
// - WIN_W  10  window width; equals the maximum code length
// - BUF_W  32  bit buffer depth; must be >= WIN_W + IN_W
// - CNT_W  6   width of bitCount; must satisfy 2**CNT_W > BUF_W
// PORTS
// - clk         in   1      clock; all logic on posedge
// - rst         in   1      synchronous active-high reset
// - inData      in   IN_W   byte from source, MSB is first in stream
// - inValid     in   1      inData valid
// - inLast      in   1      qualifies the accepted byte as the final byte of the stream
// - inReady     out  1      aligner can accept a byte this cycle
// - window      out  WIN_W  next WIN_W stream bits, MSB = oldest bit
// - windowValid out  1      window may be consumed
// - consume     in   1      decoder used bits this cycle
// - consumeLen  in   4      number of bits used, legal range 1..WIN_W
// - flush       in   1      synchronous soft clear of buffer and state
// - bitCount    out  CNT_W  valid bits held in the buffer
// - lenError    out  1      one-cycle pulse when an illegal consume is rejected
// - done        out  1      stream fully drained
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - buffer=0, bitCount=0, state=FILL, lenError=0, done=0; stats counters=0.
//   - window=0, windowValid=0 and inReady=1 follow from the cleared state.
//   - rst has priority over flush.
// - flush=1: same clear as reset, stats counters excepted. Any push or consume in that cycle is ignored.
// - Buffer: BUF_W bits, left-aligned. Bits at and below position BUF_W-1-bitCount are always 0.
// - Output timing: window=buf[BUF_W-1 -: WIN_W]. window, windowValid, inReady and done are combinational from registers only.
// - inReady = (bitCount <= BUF_W-IN_W) && state!=DRAIN && state!=DONE.
//   - Once inLast has been accepted, inReady stays 0 until reset or flush.
// - Push: accepted when inValid && inReady.
//   - The byte is written immediately below the valid bits, after any same-cycle shift.
//   - Push adds IN_W to bitCount.
// - Consume: legal when all three hold:
//   - consume && windowValid
//   - 1 <= consumeLen <= WIN_W
//   - consumeLen <= bitCount
// - Legal consume: buffer shifts left by consumeLen with zero fill; bitCount decreases by consumeLen.
// - Illegal consume (consume=1, any condition above false): no shift, bitCount unchanged, lenError=1 for the next cycle.
//   - A same-cycle push is still accepted.
// - Simultaneous legal consume and push: next bitCount = bitCount - consumeLen + IN_W, written in a single cycle.
// - Latency:
//   - A pushed byte appears in window the next cycle if it falls within the top WIN_W bits.
//   - A consume takes effect on window the next cycle. The decoder may consume every cycle.
// - State machine (2 bits):
//   - FILL:  windowValid=0. Go to RUN when the next bitCount >= WIN_W. Go to DRAIN when inLast is accepted.
//   - RUN:   windowValid=1. Return to FILL when the next bitCount < WIN_W. Go to DRAIN when inLast is accepted.
//   - DRAIN: windowValid = (bitCount>0). The window is zero-padded below the valid bits. Go to DONE when the next bitCount==0.
//   - DONE:  windowValid=0, done=1. Holds until rst or flush.
//   - When inLast is accepted, the next state is evaluated using the post-push bitCount.
// CONFIGURATION
// - HBA_STATS_EN defined: adds output ports bytesIn[15:0] and symbolsOut[15:0].
//   - bytesIn increments on each accepted push; symbolsOut on each legal consume.
//   - Both wrap from 0xFFFF to 0. Cleared only by rst.
// - HBA_STATS_EN undefined: neither the ports nor the counters exist. All other behaviour is identical.
// TESTING
// - Reset: rst=1 for 2 cycles -> bitCount=0, windowValid=0, inReady=1, done=0, window=0.
// - Fill: push 0xA5, then 0x3C, no consume.
//   - After the first push: bitCount=8, windowValid=0.
//   - After the second push: bitCount=16, windowValid=1, window=10'b1010010100.
// - Same-cycle push and consume: bitCount=16, push 0xFF and consume len 4 -> bitCount=20, window=10'b0101001111.
// - Illegal lengths: consumeLen=0, then consumeLen=11 -> each gives a lenError pulse; bitCount and window unchanged.
// - Drain: push 0x80 with inLast=1 from empty.
//   - State=DRAIN, window=10'b1000000000, inReady=0.
//   - Consume len 5 -> bitCount=3.
//   - Consume len 3 -> done=1, windowValid=0.
//   - Consume len 4 while bitCount=3 -> lenError, no change.
// - Flush mid-stream: bitCount=20, flush=1 together with a push and a consume -> bitCount=0, state=FILL, lenError=0.
//   - With HBA_STATS_EN: bytesIn keeps its value.

Source files
------------

// File: rtl/huffman_bit_aligner.sv
// huffman_bit_aligner: packs a byte stream into a left-aligned bit buffer and
// presents the oldest WIN_W bits, MSB first, to the Huffman decoder. The decoder
// reports how many bits it used each cycle and those bits are discarded.
// Optional feature macro: HBA_STATS_EN adds bytesIn/symbolsOut counter ports.
module huffman_bit_aligner #(
  parameter int IN_W  = 8,
  parameter int WIN_W = 10,
  parameter int BUF_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  inData,
  input  logic             inValid,
  input  logic             inLast,
  output logic             inReady,
  output logic [WIN_W-1:0] window,
  output logic             windowValid,
  input  logic             consume,
  input  logic [3:0]       consumeLen,
  input  logic             flush,
  output logic [CNT_W-1:0] bitCount,
  output logic             lenError,
  output logic             done
`ifdef HBA_STATS_EN
  ,
  output logic [15:0]      bytesIn,
  output logic [15:0]      symbolsOut
`endif
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stateType;

  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_W - IN_W);
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_W);
  localparam logic [CNT_W-1:0] IN_CNT    = CNT_W'(IN_W);
  localparam logic [3:0]       MAX_LEN   = 4'(WIN_W);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_bitCount;
  stateType         r_state;
  logic             r_lenError;

  stateType         w_nextState;
  logic [CNT_W-1:0] w_len;
  logic             w_legal;
  logic             w_illegal;
  logic             w_push;
  logic [CNT_W-1:0] w_cntAfter;
  logic [CNT_W-1:0] w_nextCount;
  logic [BUF_W-1:0] w_shifted;
  logic [BUF_W-1:0] w_byteAligned;
  logic [BUF_W-1:0] w_nextBuf;

  // Decode the handshake outputs from the registered state and fill level only
  always_comb begin
    windowValid = 1'b0;
    done        = 1'b0;
    inReady     = 1'b0;
    case (r_state)
      ST_FILL:  inReady = (r_bitCount <= READY_MAX);
      ST_RUN: begin
        windowValid = 1'b1;
        inReady     = (r_bitCount <= READY_MAX);
      end
      ST_DRAIN: windowValid = (r_bitCount != '0);
      ST_DONE:  done = 1'b1;
      default:  windowValid = 1'b0;
    endcase
  end

  assign window   = r_buf[BUF_W-1 -: WIN_W];
  assign bitCount = r_bitCount;
  assign lenError = r_lenError;

  // Work out this cycle's consume/push, shift out used bits, then append the byte below what is left
  always_comb begin
    w_len         = CNT_W'(consumeLen);
    w_legal       = consume && windowValid && (consumeLen != 4'd0) &&
                    (consumeLen <= MAX_LEN) && (w_len <= r_bitCount);
    w_illegal     = consume && !w_legal;
    w_push        = inValid && inReady;
    w_cntAfter    = w_legal ? (r_bitCount - w_len) : r_bitCount;
    w_shifted     = w_legal ? (r_buf << consumeLen) : r_buf;
    w_byteAligned = {inData, {(BUF_W-IN_W){1'b0}}} >> w_cntAfter;
    w_nextBuf     = w_push ? (w_shifted | w_byteAligned) : w_shifted;
    w_nextCount   = w_push ? (w_cntAfter + IN_CNT) : w_cntAfter;
  end

  // Next-state rules look at the fill level after this cycle's consume and push
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_push && inLast)           w_nextState = ST_DRAIN;
        else if (w_nextCount >= WIN_CNT) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (w_push && inLast)           w_nextState = ST_DRAIN;
        else if (w_nextCount < WIN_CNT) w_nextState = ST_FILL;
      end
      ST_DRAIN: begin
        if (w_nextCount == '0)          w_nextState = ST_DONE;
      end
      ST_DONE:  w_nextState = ST_DONE;
      default:  w_nextState = ST_FILL;
    endcase
  end

  // Buffer, fill level, state and error pulse; flush clears like reset and drops same-cycle traffic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_buf      <= '0;
      r_bitCount <= '0;
      r_state    <= ST_FILL;
      r_lenError <= 1'b0;
    end else begin
      r_buf      <= w_nextBuf;
      r_bitCount <= w_nextCount;
      r_state    <= w_nextState;
      r_lenError <= w_illegal;
    end
  end

`ifdef HBA_STATS_EN
  logic [15:0] r_bytesIn;
  logic [15:0] r_symbolsOut;

  // Traffic counters survive flush and wrap naturally; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bytesIn    <= '0;
      r_symbolsOut <= '0;
    end else if (!flush) begin
      if (w_push)  r_bytesIn    <= r_bytesIn + 16'd1;
      if (w_legal) r_symbolsOut <= r_symbolsOut + 16'd1;
    end
  end

  assign bytesIn    = r_bytesIn;
  assign symbolsOut = r_symbolsOut;
`endif

endmodule
